// File: rtl/money_pkg.sv
// Shared types and helpers for the coin-credit datapath.
package money_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'b01,
    CHANGE = 2'b10
  } state_t;

  localparam logic [31:0] DEF_COIN_VALUES = {8'd50, 8'd20, 8'd10, 8'd5};

  // Value of channel idx from a packed vector of w-bit slices (channel 0 = LSB slice).
  function automatic logic [31:0] coin_value(input logic [1023:0] vec,
                                             input int unsigned idx,
                                             input int unsigned w);
    logic [1023:0] sh;
    logic [31:0]   mask;
    sh   = vec >> (idx * w);
    mask = (32'd1 << w) - 32'd1;
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/coin_edge_det.sv
// Rising-edge detector for the coin lines. History is set on reset so that a
// line held high through reset release does not count as a coin.
module coin_edge_det #(
  parameter int NUM_COINS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] coin_in,
  output logic [NUM_COINS-1:0] coin_edge,
  output logic                 multi_edge
);

  logic [NUM_COINS-1:0] coin_prev_r;

  // Coin line history register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_prev_r <= '1;
    end else begin
      coin_prev_r <= coin_in;
    end
  end

  assign coin_edge  = coin_in & ~coin_prev_r;
  // Clearing the lowest set bit leaves something only if two or more edges are present.
  assign multi_edge = |(coin_edge & (coin_edge - {{(NUM_COINS-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/coin_credit_ctrl.sv
// Coin-credit controller: accumulates coin credit, executes purchases and
// returns change/refunds through a valid/ready handshake.
module coin_credit_ctrl
  import money_pkg::*;
#(
  parameter int                           NUM_COINS   = 4,
  parameter int                           VALUE_W     = 8,
  parameter logic [NUM_COINS*VALUE_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
  parameter int                           MAX_CREDIT  = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic [VALUE_W-1:0]   price,
  input  logic                 buy,
  input  logic                 cancel,
  input  logic                 change_ready,
  output logic [VALUE_W-1:0]   credit,
  output logic                 vend,
  output logic                 insufficient,
  output logic                 coin_reject,
  output logic                 change_valid,
  output logic [VALUE_W-1:0]   change_amount,
  output logic                 busy
);

  state_t               state_r, state_next_s;
  logic [VALUE_W-1:0]   credit_r, credit_next_s;
  logic [VALUE_W-1:0]   amount_r, amount_next_s;
  logic                 vend_r, vend_next_s;
  logic                 insuff_r, insuff_next_s;
  logic                 reject_r, reject_next_s;
  logic                 valid_r, valid_next_s;

  logic [NUM_COINS-1:0] coin_edge_s;
  logic                 multi_edge_s;
  logic                 any_edge_s;
  logic [VALUE_W-1:0]   coin_val_s;
  logic [VALUE_W:0]     sum_s;
  logic                 sum_ok_s;
  logic                 can_buy_s;
  logic [VALUE_W-1:0]   remainder_s;

  coin_edge_det #(.NUM_COINS(NUM_COINS)) u_edge (
    .clk        (clk),
    .rst        (rst),
    .coin_in    (coin_in),
    .coin_edge  (coin_edge_s),
    .multi_edge (multi_edge_s)
  );

  assign any_edge_s  = |coin_edge_s;
  assign sum_s       = {1'b0, credit_r} + {1'b0, coin_val_s};
  assign sum_ok_s    = (sum_s <= (VALUE_W+1)'(MAX_CREDIT));
  assign can_buy_s   = (credit_r >= price);
  assign remainder_s = credit_r - price;

  // Value of the edged coin; only meaningful when exactly one edge is present.
  always_comb begin
    coin_val_s = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin_edge_s[i]) begin
        coin_val_s = coin_val_s | VALUE_W'(coin_value(1024'(COIN_VALUES), i, VALUE_W));
      end else begin
        coin_val_s = coin_val_s;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ACCEPT;
      credit_r <= '0;
      amount_r <= '0;
      vend_r   <= 1'b0;
      insuff_r <= 1'b0;
      reject_r <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      credit_r <= credit_next_s;
      amount_r <= amount_next_s;
      vend_r   <= vend_next_s;
      insuff_r <= insuff_next_s;
      reject_r <= reject_next_s;
      valid_r  <= valid_next_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next_s = ACCEPT;
    case (state_r)
      ACCEPT: begin
        if (cancel) begin
          state_next_s = (credit_r != '0) ? CHANGE : ACCEPT;
        end else if (buy && can_buy_s && (remainder_s != '0)) begin
          state_next_s = CHANGE;
        end else begin
          state_next_s = ACCEPT;
        end
      end
      CHANGE: begin
        if (change_ready) begin
          state_next_s = ACCEPT;
        end else begin
          state_next_s = CHANGE;
        end
      end
      default: state_next_s = ACCEPT;
    endcase
  end

  // Next values of the credit and output registers.
  always_comb begin
    credit_next_s = credit_r;
    amount_next_s = amount_r;
    vend_next_s   = 1'b0;
    insuff_next_s = 1'b0;
    reject_next_s = 1'b0;
    valid_next_s  = valid_r;
    case (state_r)
      ACCEPT: begin
        if (cancel) begin
          reject_next_s = any_edge_s;
          if (credit_r != '0) begin
            amount_next_s = credit_r;
            credit_next_s = '0;
            valid_next_s  = 1'b1;
          end else begin
            valid_next_s  = 1'b0;
          end
        end else if (buy) begin
          reject_next_s = any_edge_s;
          if (can_buy_s) begin
            vend_next_s   = 1'b1;
            credit_next_s = '0;
            amount_next_s = remainder_s;
            valid_next_s  = (remainder_s != '0);
          end else begin
            insuff_next_s = 1'b1;
          end
        end else if (any_edge_s) begin
          if (!multi_edge_s && sum_ok_s) begin
            credit_next_s = sum_s[VALUE_W-1:0];
          end else begin
            reject_next_s = 1'b1;
          end
        end else begin
          credit_next_s = credit_r;
        end
      end
      CHANGE: begin
        reject_next_s = any_edge_s;
        if (change_ready) begin
          valid_next_s  = 1'b0;
          amount_next_s = '0;
        end else begin
          valid_next_s  = 1'b1;
        end
      end
      default: begin
        credit_next_s = '0;
        amount_next_s = '0;
        valid_next_s  = 1'b0;
      end
    endcase
  end

  assign credit        = credit_r;
  assign change_amount = amount_r;
  assign vend          = vend_r;
  assign insufficient  = insuff_r;
  assign coin_reject   = reject_r;
  assign change_valid  = valid_r;
  assign busy          = (state_r != ACCEPT);

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared cycle by cycle against an integer-level model of the credit rules.
module tb_coin_credit_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] coin_in;
  logic [7:0] price;
  logic       buy, cancel, change_ready;
  logic [7:0] credit, change_amount;
  logic       vend, insufficient, coin_reject, change_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int       m_credit, m_amt;
  bit       m_change;
  bit [3:0] m_prev;
  bit       e_vend, e_ins, e_rej;
  int       coin_val [4] = '{5, 10, 20, 50};

  coin_credit_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .coin_in       (coin_in),
    .price         (price),
    .buy           (buy),
    .cancel        (cancel),
    .change_ready  (change_ready),
    .credit        (credit),
    .vend          (vend),
    .insufficient  (insufficient),
    .coin_reject   (coin_reject),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {11'd0, credit, change_amount, vend, insufficient, coin_reject, change_valid, busy};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {11'd0, 8'(m_credit), 8'(m_amt), e_vend, e_ins, e_rej, m_change, m_change};
  endfunction

  task automatic model_reset();
    m_credit = 0; m_amt = 0; m_change = 0; m_prev = 4'b1111;
    e_vend = 0; e_ins = 0; e_rej = 0;
  endtask

  task automatic model_step();
    bit [3:0] edges;
    int n, val;
    edges = coin_in & ~m_prev;
    m_prev = coin_in;
    n = $countones(edges);
    val = 0;
    for (int i = 0; i < 4; i++) if (edges[i]) val += coin_val[i];
    e_vend = 0; e_ins = 0; e_rej = 0;
    if (!m_change) begin
      if (cancel) begin
        e_rej = (n > 0);
        if (m_credit > 0) begin m_amt = m_credit; m_credit = 0; m_change = 1; end
      end else if (buy) begin
        e_rej = (n > 0);
        if (m_credit >= int'(price)) begin
          e_vend = 1;
          m_amt = m_credit - int'(price);
          m_credit = 0;
          m_change = (m_amt > 0);
        end else begin
          e_ins = 1;
        end
      end else if (n == 1 && m_credit + val <= 200) begin
        m_credit += val;
      end else if (n > 0) begin
        e_rej = 1;
      end
    end else begin
      e_rej = (n > 0);
      if (change_ready) begin m_change = 0; m_amt = 0; end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] c, input logic [7:0] p,
                      input logic b, input logic x, input logic r);
    @(negedge clk);
    coin_in = c; price = p; buy = b; cancel = x; change_ready = r;
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    #1;
    check(tag, dut_vec(), exp_vec());
  endtask

  task automatic coin(input int ch);
    step("coin_edge", 4'(1 << ch), 8'd0, 1'b0, 1'b0, 1'b0);
    step("coin_low", 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic take_change();
    step("take_change", 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; coin_in = 4'b0001; price = 8'd0; buy = 1'b0; cancel = 1'b0; change_ready = 1'b0;
    model_reset();
    #12;
    check("reset_outputs", dut_vec(), 32'd0);

    // Line held high through reset release is not a coin.
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) step("held_high", 4'b0001, 8'd0, 1'b0, 1'b0, 1'b0);
    check("held_no_credit", {24'd0, credit}, 32'd0);
    step("release", 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
    step("repulse", 4'b0001, 8'd0, 1'b0, 1'b0, 1'b0);
    check("credit5", {24'd0, credit}, 32'd5);
    idle("idle");
    step("cancel5", 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    check("refund5", {24'd0, change_amount}, 32'd5);
    take_change();

    // 50+50+20, buy 100 -> change 20 held until ready.
    coin(3); coin(3); coin(2);
    check("credit120", {24'd0, credit}, 32'd120);
    step("buy100", 4'd0, 8'd100, 1'b1, 1'b0, 1'b0);
    check("vend_pulse", {31'd0, vend}, 32'd1);
    check("change20", {24'd0, change_amount}, 32'd20);
    for (int i = 0; i < 5; i++) step("change_hold", 4'd0, 8'(i * 37), 1'b0, 1'b0, 1'b0);
    take_change();
    check("back_accept", {31'd0, busy}, 32'd0);

    // Overflow rejection at 190, exact fill to 200.
    coin(3); coin(3); coin(3); coin(2); coin(2);
    check("credit190", {24'd0, credit}, 32'd190);
    step("over20", 4'b0100, 8'd0, 1'b0, 1'b0, 1'b0);
    check("over_reject", {31'd0, coin_reject}, 32'd1);
    idle("idle");
    coin(1);
    check("credit200", {24'd0, credit}, 32'd200);
    step("cancel200", 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    take_change();

    // Simultaneous edges, then an edge while in CHANGE.
    coin(1);
    step("dual_edge", 4'b1010, 8'd0, 1'b0, 1'b0, 1'b0);
    check("dual_reject", {31'd0, coin_reject}, 32'd1);
    idle("idle");
    step("cancel10", 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    step("coin_in_change", 4'b0001, 8'd0, 1'b0, 1'b0, 1'b0);
    check("change_reject", {31'd0, coin_reject}, 32'd1);
    idle("idle");
    take_change();

    // Insufficient credit, then buy+cancel together.
    coin(2); coin(1);
    step("buy50_short", 4'd0, 8'd50, 1'b1, 1'b0, 1'b0);
    check("insufficient", {30'd0, insufficient, vend}, 32'd2);
    step("buy_and_cancel", 4'd0, 8'd10, 1'b1, 1'b1, 1'b0);
    check("refund30", {23'd0, insufficient, change_amount}, 32'd30);
    take_change();

    // Exact price: vend without change.
    coin(3);
    step("buy50_exact", 4'd0, 8'd50, 1'b1, 1'b0, 1'b0);
    check("exact_vend", {22'd0, vend, change_valid, credit}, 32'h200);
    idle("idle");

    // Asynchronous reset in the middle of CHANGE.
    coin(3);
    step("cancel_mid", 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 check("async_reset", dut_vec(), 32'd0);
    model_reset();
    step("in_reset", 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    idle("after_reset");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      step("random", c, 8'($urandom_range(0, 150)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
